gpu_sprite_mem_responder: RTL and testbench

AXI-lite read responder that serves sprite-sheet and colour-index words to the GPU memory stage (the AR/R read master). It holds sprite data in an on-chip synchronous-read RAM and returns one 32-bit word per accepted read address. Up to two reads can be outstanding. A separate write port lets the CPU side load sprite data.

---
 rtl/gpu_pkg.sv | 11 +
 rtl/gpu_sprite_ram.sv | 22 ++
 rtl/gpu_sprite_mem_responder.sv | 86 ++++++++
 tb/tb_gpu_sprite_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GPU types and AXI-lite response codes
package gpu_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } colour_t;
    typedef colour_t colour_table_t [16];
endpackage

// File: rtl/gpu_sprite_ram.sv
// gpu_sprite_ram: simple dual-port RAM, byte-enabled write, 1-cycle read-first read
module gpu_sprite_ram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_strb
);
    logic [31:0] r_mem [DEPTH_WORDS];
    // read and write share one block so a same-word collision returns the old word
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
        for (int i = 0; i < 4; i++)
            if (i_we && i_strb[i]) r_mem[i_waddr][8*i+:8] <= i_wdata[8*i+:8];
    end
endmodule

// File: rtl/gpu_sprite_mem_responder.sv
// gpu_sprite_mem_responder: AXI-lite read responder over sprite RAM, two reads outstanding
// Optional out-of-range SLVERR checking: define GPU_SPRITE_MEM_RANGE_CHECK_EN
module gpu_sprite_mem_responder
    import gpu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    input  logic [31:0]                    s_araddr,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [31:0]                    s_rdata,
    output logic [1:0]                     s_rresp,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [31:0]                    wr_data,
    input  logic [3:0]                     wr_strb
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_err, w_ar_hs, w_pop, w_unused;
    logic [31:0]   w_ram_q;
    logic          r_inflight, r_err, r_rp, r_wp;
    logic [1:0]    r_cnt;
    logic [31:0]   r_data [2];
    logic [1:0]    r_resp [2];
    assign w_off    = s_araddr - BASE_ADDR;
    assign w_idx    = w_off[AW+1:2];
    assign w_unused = ^{w_off[1:0], w_off[31:AW+2]};
`ifdef GPU_SPRITE_MEM_RANGE_CHECK_EN
    assign w_err = (s_araddr < BASE_ADDR) || ({2'b00, w_off[31:2]} >= 32'(DEPTH_WORDS));
`else
    assign w_err = 1'b0;
`endif
    assign s_arready = !rst && (({1'b0, r_inflight} + r_cnt) < 2'd2);
    assign w_ar_hs   = s_arvalid && s_arready;
    assign s_rvalid  = !rst && (r_cnt != 2'd0);
    assign w_pop     = s_rvalid && s_rready;
    assign s_rdata   = rst ? 32'd0 : r_data[r_rp];
    assign s_rresp   = rst ? RESP_OKAY : r_resp[r_rp];
    gpu_sprite_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .i_re    (w_ar_hs && !w_err),
        .i_raddr (w_idx),
        .o_rdata (w_ram_q),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_strb  (wr_strb)
    );
    // track the read whose RAM data arrives next cycle, with its response code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_ar_hs;
            r_err      <= w_err;
        end
    end
    // in-order 2-entry response FIFO; occupancy limit guarantees a capture always fits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_rp  <= 1'b0;
            r_wp  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= 32'd0;
                r_resp[i] <= RESP_OKAY;
            end
        end else begin
            if (r_inflight) begin
                r_data[r_wp] <= r_err ? 32'd0 : w_ram_q;
                r_resp[r_wp] <= r_err ? RESP_SLVERR : RESP_OKAY;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_gpu_sprite_mem_responder.sv
// tb_gpu_sprite_mem_responder: directed table-driven bench for the sprite read responder
module tb_gpu_sprite_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_arvalid = 1'b0, s_arready;
    logic [31:0] s_araddr = 32'd0;
    logic        s_rvalid, s_rready = 1'b1;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = 10'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  wr_strb = 4'd0;
    int checks = 0, errors = 0;

    gpu_sprite_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] ra;
        logic [31:0] ed;
        logic [1:0]  er;
    } vec_t;
    vec_t v[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue_ar(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        s_arvalid = 1'b1; s_araddr = a;
        while (!s_arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ar_timeout", 32'(n), 32'd0);
        @(negedge clk);
        s_arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        issue_ar(a);
        lat = 1;
        while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
        d = s_rdata; r = s_rresp;
    endtask

    initial begin
        logic [31:0] d, first;
        logic [1:0]  r;
        int          lat, acc;
        logic        hs, seen, stable;
        logic [31:0] got[$];
        v[0] = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 32'h014, 32'hDEADBEEF, 2'b00};
        v[1] = '{1'b1, 10'd3,    32'h11223344, 4'hF, 32'h00C, 32'h11223344, 2'b00};
        v[2] = '{1'b1, 10'd3,    32'hAABBCCDD, 4'h2, 32'h00C, 32'h1122CC44, 2'b00};
        v[3] = '{1'b1, 10'd0,    32'hA5A5A5A5, 4'hF, 32'h000, 32'hA5A5A5A5, 2'b00};
`ifdef GPU_SPRITE_MEM_RANGE_CHECK_EN
        v[4] = '{1'b0, 10'd0,    32'h0,        4'h0, 32'h1000, 32'h0,       2'b10};
        v[8] = '{1'b0, 10'd0,    32'h0,        4'h0, 32'h1014, 32'h0,       2'b10};
`else
        v[4] = '{1'b0, 10'd0,    32'h0,        4'h0, 32'h1000, 32'hA5A5A5A5, 2'b00};
        v[8] = '{1'b0, 10'd0,    32'h0,        4'h0, 32'h1014, 32'hDEADBEEF, 2'b00};
`endif
        v[5] = '{1'b1, 10'd1023, 32'hCAFEF00D, 4'hF, 32'hFFC, 32'hCAFEF00D, 2'b00};
        v[6] = '{1'b1, 10'd1023, 32'h00000077, 4'h1, 32'hFFC, 32'hCAFEF077, 2'b00};
        v[7] = '{1'b1, 10'd1023, 32'h12000000, 4'h8, 32'hFFC, 32'h12FEF077, 2'b00};

        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_rresp", 32'(s_rresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 32'(s_arready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            if (v[i].we) do_write(v[i].wa, v[i].wd, v[i].ws);
            do_read(v[i].ra, d, r, lat);
            chk($sformatf("vec%0d_rdata", i), d, v[i].ed);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(v[i].er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        do_write(10'd7, 32'd1, 4'hF);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'd2; wr_strb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 32'h1C;
        chk("coll_arready", 32'(s_arready), 32'd1);
        @(negedge clk);
        wr_en = 1'b0; s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("coll_old", s_rdata, 32'd1);
        do_read(32'h1C, d, r, lat);
        chk("coll_new", d, 32'd2);

        do_write(10'd0, 32'h100, 4'hF);
        do_write(10'd1, 32'h101, 4'hF);
        do_write(10'd2, 32'h102, 4'hF);
        @(negedge clk);
        s_rready = 1'b0; s_arvalid = 1'b1; s_araddr = 32'h0;
        hs = s_arready; acc = 0; seen = 1'b0; stable = 1'b1; first = 32'h0;
        repeat (8) begin
            @(negedge clk);
            if (hs) begin acc++; if (acc == 3) s_arvalid = 1'b0; else s_araddr = 32'(acc * 4); end
            hs = s_arvalid && s_arready;
            if (s_rvalid) begin
                if (!seen) begin first = s_rdata; seen = 1'b1; end
                else if (s_rdata !== first) stable = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_arready_low", 32'(s_arready), 32'd0);
        chk("bp_rvalid", 32'(s_rvalid), 32'd1);
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_head", first, 32'h100);
        s_rready = 1'b1;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            if (s_rvalid) got.push_back(s_rdata);
            hs = s_arvalid && s_arready;
            @(negedge clk);
            if (hs) begin acc++; if (acc == 3) s_arvalid = 1'b0; else s_araddr = 32'(acc * 4); end
        end
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_order%0d", i), got.size() > i ? got[i] : 32'hFFFF_FFFF, 32'h100 + 32'(i));
        s_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_no_dup", 32'(s_rvalid), 32'd0);

        s_rready = 1'b0;
        issue_ar(32'h14);
        issue_ar(32'h14);
        repeat (2) @(negedge clk);
        chk("mid_rvalid", 32'(s_rvalid), 32'd1);
        chk("mid_arready", 32'(s_arready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("mid_rst_arready", 32'(s_arready), 32'd0);
        chk("mid_rst_rdata", s_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_arready", 32'(s_arready), 32'd1);
        chk("mid_after_rvalid", 32'(s_rvalid), 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_no_stale", 32'(s_rvalid), 32'd0);
        s_rready = 1'b1;
        do_read(32'h14, d, r, lat);
        chk("mid_fresh_rdata", d, 32'hDEADBEEF);
        chk("mid_fresh_latency", 32'(lat), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
